// File: rtl/bullet_scheduler.sv
// Shared bullet-slot pool for two tanks: latches fire requests, grants slots round-robin once
// per frame, moves live bullets, frees those leaving the screen and flags bullet pixels.
module bullet_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int MAX_PER_TANK = 2,
  parameter int BULLET_SIZE  = 8,
  parameter int TANK_SIZE    = 32,
  parameter int BULLET_STEP  = 4,
  parameter int COOLDOWN     = 15,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [1:0]           fire_req,
  input  logic [9:0]           tank0_X,
  input  logic [9:0]           tank0_Y,
  input  logic [2:0]           tank0_dir,
  input  logic [9:0]           tank1_X,
  input  logic [9:0]           tank1_Y,
  input  logic [2:0]           tank1_dir,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic [1:0]           fire_grant,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic                 is_bullet,
  output logic                 bullet_owner,
  output logic                 busy
);
  localparam int          IW   = $clog2(NUM_SLOTS);
  localparam int          CW   = $clog2(COOLDOWN + 1);
  localparam logic [10:0] HALF = 11'(TANK_SIZE / 2 - BULLET_SIZE / 2);
  localparam logic [10:0] BSZ  = 11'(BULLET_SIZE);
  localparam logic [10:0] TSZ  = 11'(TANK_SIZE);
  localparam logic [10:0] STEP = 11'(BULLET_STEP);
  localparam logic [IW-1:0] LAST = IW'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, ARB_A, ARB_B} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q;
  logic [9:0]           slot_x   [NUM_SLOTS];
  logic [9:0]           slot_y   [NUM_SLOTS];
  logic [2:0]           slot_dir [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_owner;
  logic [1:0]           pending;
  logic [CW-1:0]        cooldown [2];
  logic                 rr_ptr, granted_q;
  logic [2:0]           fsync;
  logic                 tick;

  logic [10:0]   mv_x, mv_y, sp_x, sp_y;
  logic          mv_off;
  logic          arb_tank, arb_cycle, free_found, dir_ok, grant_ok;
  logic [IW-1:0] free_idx;
  logic [3:0]    owned;
  logic [9:0]    arb_x, arb_y;
  logic [2:0]    arb_dir;

  // Coordinates are 11 bits wide so that a wrap below zero lands in bit 10.
  function automatic logic off_screen(input logic [10:0] px, input logic [10:0] py);
    return px[10] || py[10] ||
           ((px + BSZ - 11'd1) > 11'(X_MAX)) || ((py + BSZ - 11'd1) > 11'(Y_MAX));
  endfunction

  // NOTE: the frame_clk synchroniser carries no reset so a reset taken while frame_clk is high
  // cannot fabricate a tick once it is released.
  always_ff @(posedge Clk) fsync <= {fsync[1:0], frame_clk};
  assign tick = fsync[1] & ~fsync[2];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = MOVE;
      MOVE:    if (idx_q == LAST) state_d = ARB_A;
      ARB_A:   state_d = ARB_B;
      ARB_B:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mv_x = {1'b0, slot_x[idx_q]};
    mv_y = {1'b0, slot_y[idx_q]};
    case (slot_dir[idx_q])
      3'd1:    mv_y = {1'b0, slot_y[idx_q]} - STEP;
      3'd2:    mv_x = {1'b0, slot_x[idx_q]} + STEP;
      3'd3:    mv_x = {1'b0, slot_x[idx_q]} - STEP;
      3'd4:    mv_y = {1'b0, slot_y[idx_q]} + STEP;
      default: ;
    endcase
    mv_off = off_screen(mv_x, mv_y);
  end

  always_comb begin
    arb_cycle = (state_q == ARB_A) || (state_q == ARB_B);
    arb_tank  = (state_q == ARB_B) ? ~rr_ptr : rr_ptr;
    arb_x     = arb_tank ? tank1_X   : tank0_X;
    arb_y     = arb_tank ? tank1_Y   : tank0_Y;
    arb_dir   = arb_tank ? tank1_dir : tank0_dir;
    free_found = 1'b0;
    free_idx   = '0;
    owned      = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!slot_active[s]) begin
        free_found = 1'b1;
        free_idx   = IW'(s);
      end else if (slot_owner[s] == arb_tank) begin
        owned = owned + 4'd1;
      end
    end
    dir_ok = 1'b1;
    sp_x   = {1'b0, arb_x};
    sp_y   = {1'b0, arb_y};
    case (arb_dir)
      3'd1:    begin sp_x = {1'b0, arb_x} + HALF; sp_y = {1'b0, arb_y} - BSZ;  end
      3'd2:    begin sp_x = {1'b0, arb_x} + TSZ;  sp_y = {1'b0, arb_y} + HALF; end
      3'd3:    begin sp_x = {1'b0, arb_x} - BSZ;  sp_y = {1'b0, arb_y} + HALF; end
      3'd4:    begin sp_x = {1'b0, arb_x} + HALF; sp_y = {1'b0, arb_y} + TSZ;  end
      default: dir_ok = 1'b0;
    endcase
    grant_ok = arb_cycle && pending[arb_tank] && free_found && dir_ok &&
               (owned < 4'(MAX_PER_TANK)) && !off_screen(sp_x, sp_y);
    fire_grant = '0;
    if (grant_ok && !Reset) fire_grant[arb_tank] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments only; later writes in this block
    // deliberately override earlier ones (e.g. a serve clears pending over the request latch).
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      slot_active <= '0;
      slot_owner  <= '0;
      // NOTE: the slot file is small and must come up with defined coordinates, so it is reset.
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_x[s]   <= '0;
        slot_y[s]   <= '0;
        slot_dir[s] <= '0;
      end
      pending     <= '0;
      cooldown[0] <= '0;
      cooldown[1] <= '0;
      rr_ptr      <= 1'b0;
      granted_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= (state_q == MOVE && idx_q != LAST) ? idx_q + IW'(1) : '0;
      for (int i = 0; i < 2; i++) begin
        if (fire_req[i] && cooldown[i] == '0) pending[i] <= 1'b1;
        if (state_q == IDLE && tick && cooldown[i] != '0) cooldown[i] <= cooldown[i] - CW'(1);
      end
      if (arb_cycle) pending[arb_tank] <= 1'b0;
      if (state_q == MOVE && slot_active[idx_q]) begin
        if (mv_off) begin
          slot_active[idx_q] <= 1'b0;
        end else begin
          slot_x[idx_q] <= mv_x[9:0];
          slot_y[idx_q] <= mv_y[9:0];
        end
      end
      if (grant_ok) begin
        slot_active[free_idx] <= 1'b1;
        slot_owner[free_idx]  <= arb_tank;
        slot_x[free_idx]      <= sp_x[9:0];
        slot_y[free_idx]      <= sp_y[9:0];
        slot_dir[free_idx]    <= arb_dir;
        cooldown[arb_tank]    <= CW'(COOLDOWN);
      end
      if (state_q == IDLE)  granted_q <= 1'b0;
      else if (grant_ok)    granted_q <= 1'b1;
      if (state_q == ARB_B && (granted_q || grant_ok)) rr_ptr <= ~rr_ptr;
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    is_bullet    = 1'b0;
    bullet_owner = 1'b0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (slot_active[s] &&
          {1'b0, DrawX} >= {1'b0, slot_x[s]} && {1'b0, DrawX} <= {1'b0, slot_x[s]} + BSZ - 11'd1 &&
          {1'b0, DrawY} >= {1'b0, slot_y[s]} && {1'b0, DrawY} <= {1'b0, slot_y[s]} + BSZ - 11'd1) begin
        is_bullet    = 1'b1;
        bullet_owner = slot_owner[s];
      end
    end
  end
endmodule
